// File: rtl/stream_mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer: channel-count limits,
// channel index type, lock FSM states and the round-robin distance helper.
package stream_mux_pkg;

    localparam int unsigned NChMin = 2;
    localparam int unsigned NChMax = 16;

    typedef logic [3:0] ch_idx_t;

    typedef enum logic {StArb, StLocked} lock_state_e;

    // Position of channel ch in the search order starting at p, modulo n.
    function automatic int unsigned rr_dist(input int unsigned ch, input int unsigned p,
                                            input int unsigned n);
        int unsigned d;
        d = ch + n - p;
        return (d >= n) ? d - n : d;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins, or only
// lock_ch when lock_en is set.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int unsigned N_CH = 4
) (
    input  logic [N_CH-1:0] req,
    input  ch_idx_t         ptr,
    input  logic            lock_en,
    input  ch_idx_t         lock_ch,
    output logic [N_CH-1:0] gnt,
    output ch_idx_t         gnt_idx,
    output logic            gnt_valid
);

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            for (int unsigned j = 0; j < N_CH; j++) begin
                if (!gnt_valid && req[j] && (rr_dist(j, 32'(ptr), N_CH) == i) &&
                    (!lock_en || (ch_idx_t'(j) == lock_ch))) begin
                    gnt[j]    = 1'b1;
                    gnt_idx   = ch_idx_t'(j);
                    gnt_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/stream_rr_mux.sv
// N-channel valid/ready stream mux with round-robin arbitration and a registered output.
// Define STREAM_RR_MUX_LOCK_EN to hold the grant on one channel until its in_last beat.
module stream_rr_mux
    import stream_mux_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned W     = 8,
    parameter int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   in_valid,
    input  logic [N_CH*W-1:0] in_data,
    input  logic [N_CH-1:0]   in_last,
    output logic [N_CH-1:0]   in_ready,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic              out_last,
    output logic [SEL_W-1:0]  out_sel,
    input  logic              out_ready
);

    if (N_CH < NChMin || N_CH > NChMax) begin : g_bad_n_ch
        $error("stream_rr_mux: N_CH out of range");
    end

    logic              valid_q, valid_d;
    logic [W-1:0]      data_q, data_d;
    logic              last_q, last_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    ch_idx_t           ptr_q, ptr_d;

    logic [N_CH-1:0]   gnt;
    ch_idx_t           gnt_idx;
    logic              gnt_valid;
    logic              lock_en;
    ch_idx_t           lock_ch;
    logic              load;
    logic              xfer;
    logic [W-1:0]      mux_data;
    logic              mux_last;

    assign load = ~valid_q | out_ready;
    assign xfer = load & gnt_valid;
    // Held low during reset so no producer sees its beat accepted.
    assign in_ready = (load && rst_n) ? gnt : '0;

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr_q),
        .lock_en   (lock_en),
        .lock_ch   (lock_ch),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        mux_data = '0;
        mux_last = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (gnt[i]) begin
                mux_data = in_data[i*W +: W];
                mux_last = in_last[i];
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (load) begin
            valid_d = xfer;
            if (xfer) begin
                data_d = mux_data;
                last_d = mux_last;
                sel_d  = gnt_idx[SEL_W-1:0];
                ptr_d  = (gnt_idx == ch_idx_t'(N_CH - 1)) ? '0 : gnt_idx + ch_idx_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef STREAM_RR_MUX_LOCK_EN
    lock_state_e state_q, state_d;
    ch_idx_t     lock_ch_q, lock_ch_d;

    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        unique case (state_q)
            StArb: begin
                if (xfer && !mux_last) begin
                    state_d   = StLocked;
                    lock_ch_d = gnt_idx;
                end
            end
            StLocked: begin
                if (xfer && mux_last) begin
                    state_d = StArb;
                end
            end
            default: state_d = StArb;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StArb;
            lock_ch_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_ch_q <= lock_ch_d;
        end
    end

    assign lock_en = (state_q == StLocked);
    assign lock_ch = lock_ch_q;
`else
    assign lock_en = 1'b0;
    assign lock_ch = '0;
`endif

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign out_sel   = sel_q;

endmodule

// File: doc/stream_rr_mux.md
# stream_rr_mux

Parametrised N-channel streaming multiplexer: the next generation of our 4:1 data-select mux. Selection comes from a round-robin arbiter, not external select lines. Each input is a valid/ready stream; the winner's beat is captured into a single registered output stage with its own valid/ready handshake. It sits between several producer streams and one shared consumer, for example several sources feeding one bus.

## Interface
- `N_CH`, 4, number of input channels; legal range 2..16.
- `W`, 8, data width per channel in bits.
- `SEL_W`, `$clog2(N_CH)`, width of the channel index (derived; not overridden).

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in N_CH: per-channel beat valid.
- `in_data` in N_CH*W: channel i occupies bits [i*W +: W].
- `in_last` in N_CH: per-channel end-of-packet marker.
- `in_ready` out N_CH: per-channel accept; at most one bit high in any cycle.
- `out_valid` out 1: output register holds a beat.
- `out_data` out W: registered data.
- `out_last` out 1: registered last marker.
- `out_sel` out SEL_W: index of the channel that produced the current output beat.
- `out_ready` in 1: consumer accept.

## Operation
- `load = ~out_valid | out_ready`. The output register accepts a new beat only when `load` is 1.
- Arbitration:
  - Search order starts at pointer `ptr` and wraps modulo N_CH.
  - The grant `g` is the first channel with `in_valid` high in that order.
  - `in_ready[g] = load`; all other `in_ready` bits are 0.
  - `in_ready` is combinational from `in_valid`, `ptr`, lock state and `out_ready`.
- Transfer on input g (`in_valid[g] & in_ready[g]`):
  - `out_data <= in_data[g]`, `out_last <= in_last[g]`, `out_sel <= g`, `out_valid <= 1`.
  - `ptr <= (g+1) mod N_CH`. When g = N_CH-1, ptr wraps to 0.
- When `load` is 1 and no input is valid: `out_valid <= 0`; data, last and sel hold their values.
- When `load` is 0: all output registers hold and every `in_ready` bit is 0.
- Simultaneous output drain and input accept in the same cycle: the new beat replaces the old one with no bubble.
- Data, last and sel are never changed while `out_valid & ~out_ready`.

## Timing
- Latency: an input beat accepted at edge k appears on the output at edge k (registered). The consumer sees it from the cycle after the accepting edge.
- Throughput: 1 beat per cycle while `out_ready` is held at 1.
- Fairness: with all N_CH channels continuously valid, each channel is served exactly once every N_CH beats.
- Reset values: `out_valid` 0, `out_data` 0, `out_last` 0, `out_sel` 0, `ptr` 0, state ARB.
- Reset asserted mid-packet or mid-stall: the held beat is dropped and the lock is cleared immediately, asynchronously.
- Input protocol: producers must hold `in_data`/`in_last` stable while valid and not ready. The block does not check this.

## Configuration
- `STREAM_RR_MUX_LOCK_EN` defined (packet lock):
  - Two-state FSM: ARB and LOCKED(ch).
  - ARB: arbitrate as above. On accepting a beat with `in_last=0` from g, go to LOCKED with ch=g.
  - LOCKED: only channel ch may be granted, even if others are valid and earlier in round-robin order. On accepting a beat with `in_last=1` from ch, return to ARB, with `ptr` = ch+1.
  - A packet that is a single beat with `in_last=1` leaves the FSM in ARB.
- Macro undefined:
  - Every beat is arbitrated independently; there is no FSM.
  - `in_last` is only passed through to `out_last`.

## Structure
- Shared package `stream_mux_pkg`: the `N_CH` legality limits, and a `ch_idx_t` typedef sized for the maximum N_CH (16).
- One sub-module: `rr_arbiter`.
  - Inputs: request vector, pointer, lock enable, lock channel.
  - Outputs: one-hot grant and encoded grant index. Purely combinational.
- The top level holds the pointer, the FSM and the output register.

## Test plan
- Reset: `rst_n=0` with all inputs valid. Response: `out_valid=0`, `in_ready=0`, `out_sel=0`. After release, the first grant goes to channel 0.
- All 4 channels valid, `out_ready=1`, `in_data[i]=8'hA0+i`. Response: output sequence A0, A1, A2, A3, A0; one beat per cycle.
- Only channel 2 valid, `out_ready=0` for 3 cycles, then 1. Response: `out_data` holds 8'hA2 and `in_ready[2]=0` during the stall. Ch2 is re-accepted in the cycle `out_ready` rises.
- `ptr=3`, channels 0 and 3 valid. Response: channel 3 is granted first, then `ptr` wraps to 0 and channel 0 is granted.
- LOCK_EN defined: channel 1 sends a 3-beat packet with last on beat 3, while channel 2 is continuously valid. Response: out_sel sequence 1, 1, 1, 2. Without the macro: 1, 2, 1, 2, 1.
- Reset is pulsed while LOCKED on channel 1. Response: after release, `out_valid=0` and arbitration starts from channel 0 with no lock.
